alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Sequences operations into the shared ALU (single-cycle ops plus multi-cycle mult/div).
//  Accepts one request at a time over a valid/ready interface and drives the ALU operand and opcode ports.
//  Pulses alu_start for mult (00010) and div (00011), then waits for the ALU valid or a timeout.
//  Returns result, flag and error over a valid/ready response interface.
//  Sits between the multi-cycle CPU control FSM and the ALU.
// PARAMETERS
//  WIDTH    32  operand/result width
//  TIMEOUT  64  max cycles in WAIT before abort; >=2; counter width $clog2(TIMEOUT+1)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      asynchronous, active-low reset
//  req_valid   in   1      request valid
//  req_ready   out  1      request accepted when req_valid&req_ready
//  req_op      in   5      ALU opcode (00000..01110 legal)
//  req_a       in   WIDTH  operand 1
//  req_b       in   WIDTH  operand 2
//  alu_in1     out  WIDTH  to ALU operand 1 (latched req_a)
//  alu_in2     out  WIDTH  to ALU operand 2 (latched req_b)
//  alu_opcode  out  5      to ALU opcode
//  alu_start   out  1      one-cycle start pulse, mult/div only
//  alu_result  in   WIDTH  ALU result
//  alu_flag    in   1      ALU compare flag
//  alu_valid   in   1      ALU multi-cycle done
//  rsp_valid   out  1      response valid
//  rsp_ready   in   1      response consumed when rsp_valid&rsp_ready
//  rsp_result  out  WIDTH  captured result
//  rsp_flag    out  1      captured flag
//  rsp_err     out  1      1 = illegal opcode or timeout
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all outputs 0, except alu_opcode=5'b11111 (ALU default, starts low).
//  FSM states IDLE, EXEC, ISSUE, WAIT, RESP. All outputs are registered or decoded from state only.
//  IDLE: req_ready=1; alu_opcode=11111.
//    On accept, latch op/a/b and go to:
//      op>01110 -> RESP, err=1, result=0, flag=0
//      op in {00010, 00011} -> ISSUE
//      otherwise -> EXEC
//  EXEC: drive latched op/operands; capture alu_result and alu_flag at the clock edge -> RESP.
//    Latency: accept edge to rsp_valid = 2 cycles.
//  ISSUE: alu_start=1 for exactly one cycle; clear timeout counter -> WAIT.
//  WAIT: alu_start=0; op and operands held.
//    alu_valid=1 -> capture result/flag, err=0 -> RESP.
//    Else counter++; counter==TIMEOUT-1 and no alu_valid -> RESP, err=1, result=0.
//    alu_valid wins on the timeout cycle.
//  RESP: rsp_valid=1; rsp_* stable until handshake. rsp_ready=1 -> IDLE.
//    Back-to-back: the next request is accepted in the IDLE cycle after RESP (no same-cycle accept).
//  alu_valid or alu_flag seen outside EXEC/WAIT is ignored.
//  req_ready=0 in every state except IDLE. req_* changes while not ready are ignored.
//  Reset mid-operation (any state): abort immediately to reset values; no response for the aborted op.
//  Flag is captured for every legal op; it is meaningful for 00000, 01000, 01011 and 01100.
// CONFIGURATION
//  ALU_ISSUE_PERF_EN defined:
//    adds out ports perf_ops[31:0] (completed responses, counted at the rsp handshake)
//    and perf_busy[31:0] (cycles with state!=IDLE).
//    Both reset to 0, wrap at 2^32, and are not otherwise clearable.
//  Undefined: ports and counters are absent; behaviour is otherwise identical.
// TESTING
//  add a=5 b=5 -> rsp_valid exactly 2 cycles after accept; result=10, flag=1, err=0; alu_start never 1.
//  mult a=7 b=6 with stub valid 5 cycles after start -> one alu_start pulse; result=42, err=0.
//  div with stub never asserting valid, TIMEOUT=8 -> rsp after 8 WAIT cycles; err=1, result=0.
//  op=10101 -> rsp 1 cycle after accept, err=1, no alu_start.
//  rsp_ready held 0 for 4 cycles -> rsp_* stable and req_ready=0.
//    Then rsp_ready=1, next request accepted one cycle later.
//  rst=0 asserted in WAIT -> outputs 0 and alu_opcode=11111 at once; with PERF_EN, perf counters=0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue sequencer between the multi-cycle CPU control FSM and
// the shared ALU. One request at a time is accepted on a valid/ready port,
// driven into the ALU (single-cycle ops directly, mult/div with a start pulse
// and a bounded wait for the ALU done strobe), and returned on a valid/ready
// response port with result, flag and error.
// Optional build macro: ALU_ISSUE_PERF_EN adds perf_ops / perf_busy counters.
module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [4:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_in1,
  output logic [WIDTH-1:0] alu_in2,
  output logic [4:0]       alu_opcode,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flag,
  input  logic             alu_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_flag,
  output logic             rsp_err
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_busy
`endif
);

  // Timeout counter spans 0..TIMEOUT so the terminal value always fits.
  localparam int              CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  localparam logic [4:0]      OP_MULT  = 5'b00010;
  localparam logic [4:0]      OP_DIV   = 5'b00011;
  localparam logic [4:0]      OP_LAST  = 5'b01110;
  // Opcode presented to the ALU while nothing is being issued.
  localparam logic [4:0]      OP_NONE  = 5'b11111;

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EXEC  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t           state_r;
  state_t           state_s;

  logic [WIDTH-1:0] in1_r;
  logic [WIDTH-1:0] in1_s;
  logic [WIDTH-1:0] in2_r;
  logic [WIDTH-1:0] in2_s;
  logic [4:0]       opcode_r;
  logic [4:0]       opcode_s;
  logic             start_r;
  logic             start_s;
  logic             req_ready_r;
  logic             req_ready_s;
  logic             rsp_valid_r;
  logic             rsp_valid_s;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] result_s;
  logic             flag_r;
  logic             flag_s;
  logic             err_r;
  logic             err_s;
  logic [CW-1:0]    cnt_r;
  logic [CW-1:0]    cnt_s;

  // Next-state and next-output decode; every output is registered from these.
  always_comb begin
    state_s     = state_r;
    in1_s       = in1_r;
    in2_s       = in2_r;
    opcode_s    = opcode_r;
    result_s    = result_r;
    flag_s      = flag_r;
    err_s       = err_r;
    cnt_s       = cnt_r;
    req_ready_s = 1'b0;
    rsp_valid_s = 1'b0;
    start_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (req_valid && req_ready_r) begin
          in1_s = req_a;
          in2_s = req_b;
          if (req_op > OP_LAST) begin
            // Illegal opcode never reaches the ALU; answer with an error.
            state_s  = ST_RESP;
            opcode_s = OP_NONE;
            result_s = ZERO_W;
            flag_s   = 1'b0;
            err_s    = 1'b1;
          end else if ((req_op == OP_MULT) || (req_op == OP_DIV)) begin
            state_s  = ST_ISSUE;
            opcode_s = req_op;
          end else begin
            state_s  = ST_EXEC;
            opcode_s = req_op;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_EXEC: begin
        // Single-cycle op: ALU output is valid during this cycle.
        result_s = alu_result;
        flag_s   = alu_flag;
        err_s    = 1'b0;
        state_s  = ST_RESP;
      end

      ST_ISSUE: begin
        cnt_s   = CNT_ZERO;
        state_s = ST_WAIT;
      end

      ST_WAIT: begin
        if (alu_valid) begin
          // A done strobe on the last allowed cycle still counts as success.
          result_s = alu_result;
          flag_s   = alu_flag;
          err_s    = 1'b0;
          state_s  = ST_RESP;
        end else if (cnt_r == CNT_LAST) begin
          result_s = ZERO_W;
          flag_s   = 1'b0;
          err_s    = 1'b1;
          state_s  = ST_RESP;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_s  = ST_IDLE;
          opcode_s = OP_NONE;
        end else begin
          state_s = ST_RESP;
        end
      end

      default: begin
        state_s  = ST_IDLE;
        opcode_s = OP_NONE;
      end
    endcase

    // Handshake and strobe outputs follow the state being entered, so they
    // are registered yet line up with the state they belong to.
    req_ready_s = (state_s == ST_IDLE);
    rsp_valid_s = (state_s == ST_RESP);
    start_s     = (state_s == ST_ISSUE);
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Operand, opcode, handshake and response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in1_r       <= ZERO_W;
      in2_r       <= ZERO_W;
      opcode_r    <= OP_NONE;
      start_r     <= 1'b0;
      req_ready_r <= 1'b0;
      rsp_valid_r <= 1'b0;
      result_r    <= ZERO_W;
      flag_r      <= 1'b0;
      err_r       <= 1'b0;
      cnt_r       <= CNT_ZERO;
    end else begin
      in1_r       <= in1_s;
      in2_r       <= in2_s;
      opcode_r    <= opcode_s;
      start_r     <= start_s;
      req_ready_r <= req_ready_s;
      rsp_valid_r <= rsp_valid_s;
      result_r    <= result_s;
      flag_r      <= flag_s;
      err_r       <= err_s;
      cnt_r       <= cnt_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign alu_in1    = in1_r;
  assign alu_in2    = in2_r;
  assign alu_opcode = opcode_r;
  assign alu_start  = start_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_result = result_r;
  assign rsp_flag   = flag_r;
  assign rsp_err    = err_r;

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_ops_r;
  logic [31:0] perf_busy_r;

  // Free-running wrap-around counters: completed responses and busy cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_ops_r  <= 32'd0;
      perf_busy_r <= 32'd0;
    end else begin
      if (rsp_valid_r && rsp_ready) begin
        perf_ops_r <= perf_ops_r + 32'd1;
      end else begin
        perf_ops_r <= perf_ops_r;
      end
      if (state_r != ST_IDLE) begin
        perf_busy_r <= perf_busy_r + 32'd1;
      end else begin
        perf_busy_r <= perf_busy_r;
      end
    end
  end

  assign perf_ops  = perf_ops_r;
  assign perf_busy = perf_busy_r;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl (TIMEOUT=8). A transaction-level
// model predicts acceptance, start pulse, response cycle and response content
// from each request; a per-cycle compare process checks the DUT against it,
// and directed runs pin latencies and results with hand-computed literals.
module tb_alu_issue_ctrl;

  localparam int WIDTH   = 32;
  localparam int TIMEOUT = 8;

  logic             clk;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [4:0]       req_op;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [4:0]       alu_opcode;
  logic             alu_start;
  logic [WIDTH-1:0] alu_result;
  logic             alu_flag;
  logic             alu_valid;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_flag;
  logic             rsp_err;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0]      perf_ops;
  logic [31:0]      perf_busy;
`endif

  alu_issue_ctrl #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .alu_in1    (alu_in1),
    .alu_in2    (alu_in2),
    .alu_opcode (alu_opcode),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .alu_flag   (alu_flag),
    .alu_valid  (alu_valid),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .rsp_err    (rsp_err)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_busy  (perf_busy)
`endif
  );

  int vectors    = 0;
  int miscompares = 0;
  int starts     = 0;

  // stub ALU behaviour
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a * b;
      5'd3:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd4:    return a & b;
      5'd5:    return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic ref_flag(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == 5'd8 || op == 5'd12) return (a < b);
    return (a == b);
  endfunction

  int   mc_delay  = 0;   // cycles from start pulse to ALU done (0 = never)
  int   due       = -1;
  logic stub_hit  = 1'b0;
  logic force_valid = 1'b0;

  assign alu_result = ref_res(alu_opcode, alu_in1, alu_in2);
  assign alu_flag   = ref_flag(alu_opcode, alu_in1, alu_in2);
  assign alu_valid  = force_valid | stub_hit;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- transaction-level model ----------------
  int          mcyc = 0;
  bit          m_ready = 0, m_busy = 0, m_resp = 0, m_legal = 0;
  int          m_start_cyc = -1, m_rsp_cyc = 0;
  logic [4:0]  m_op = 5'd0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0, m_res = 32'd0;
  logic        m_flag = 1'b0, m_err = 1'b0;
  logic [31:0] m_pops = 32'd0, m_pbusy = 32'd0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_ready = 0; m_busy = 0; m_resp = 0; m_start_cyc = -1;
        m_pops = 32'd0; m_pbusy = 32'd0;
      end else begin
        if (m_busy) m_pbusy = m_pbusy + 32'd1;
        if (m_busy) begin
          if (m_resp && rsp_ready) begin
            m_busy = 0; m_resp = 0; m_ready = 1; m_pops = m_pops + 32'd1;
          end
        end else if (m_ready && req_valid) begin
          m_busy = 1; m_ready = 0;
          m_op = req_op; m_a = req_a; m_b = req_b;
          m_start_cyc = -1;
          if (req_op > 5'd14) begin
            m_legal = 0; m_rsp_cyc = mcyc + 1;
            m_res = 32'd0; m_flag = 1'b0; m_err = 1'b1;
          end else if (req_op == 5'd2 || req_op == 5'd3) begin
            m_legal = 1; m_start_cyc = mcyc + 1;
            if (mc_delay >= 1 && mc_delay <= TIMEOUT) begin
              m_rsp_cyc = mcyc + 2 + mc_delay;
              m_res = ref_res(req_op, req_a, req_b);
              m_flag = ref_flag(req_op, req_a, req_b); m_err = 1'b0;
            end else begin
              m_rsp_cyc = mcyc + 2 + TIMEOUT;
              m_res = 32'd0; m_flag = 1'b0; m_err = 1'b1;
            end
          end else begin
            m_legal = 1; m_rsp_cyc = mcyc + 2;
            m_res = ref_res(req_op, req_a, req_b);
            m_flag = ref_flag(req_op, req_a, req_b); m_err = 1'b0;
          end
        end else begin
          m_ready = 1;
        end
        mcyc = mcyc + 1;
        if (m_busy && mcyc >= m_rsp_cyc) m_resp = 1;
      end
    end
  end

  // ---------------- multi-cycle ALU stub ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) due = -1;
      else if (alu_start) due = (mc_delay > 0) ? mcyc + mc_delay : -1;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      stub_hit = rst && (due >= 0) && (mcyc == due);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_alu_start", {31'd0, alu_start}, 32'd0);
        chk("rst_opcode",    {27'd0, alu_opcode}, 32'h1F);
        chk("rst_result",    rsp_result, 32'd0);
        chk("rst_in1",       alu_in1, 32'd0);
      end else begin
        if (alu_start) starts++;
        chk("req_ready", {31'd0, req_ready}, {31'd0, m_ready});
        chk("alu_start", {31'd0, alu_start}, {31'd0, (m_busy && mcyc == m_start_cyc)});
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_resp});
        if (m_resp) begin
          chk("rsp_result", rsp_result, m_res);
          chk("rsp_flag", {31'd0, rsp_flag}, {31'd0, m_flag});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        end
        if (!m_busy) begin
          chk("idle_opcode", {27'd0, alu_opcode}, 32'h1F);
        end else if (m_legal && !m_resp) begin
          chk("busy_opcode", {27'd0, alu_opcode}, {27'd0, m_op});
          chk("busy_in1", alu_in1, m_a);
          chk("busy_in2", alu_in2, m_b);
        end
`ifdef ALU_ISSUE_PERF_EN
        chk("perf_ops", perf_ops, m_pops);
        chk("perf_busy", perf_busy, m_pbusy);
`endif
      end
    end
  end

  // One directed transaction with hand-computed latency and response.
  task automatic run(input string nm, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int d, input int hold, input int exp_lat, input logic [31:0] exp_res,
                     input logic exp_flag, input logic exp_err, input int exp_starts);
    int acc;
    int rc;
    bit got;
    mc_delay = d;
    starts = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; rsp_ready = 1'b0;
    got = 0; acc = 0;
    for (int i = 0; i < 20; i++) begin
      if (!got) begin
        @(negedge clk);
        if (req_ready) begin got = 1; acc = mcyc; end
      end
    end
    chk({nm, "_accept"}, {31'd0, got}, 32'd1);
    // Keep valid high with junk while busy: must be ignored.
    @(posedge clk); #1;
    req_op = 5'b00100; req_a = $urandom; req_b = $urandom;
    got = 0; rc = 0;
    for (int i = 0; i < 40; i++) begin
      if (!got) begin
        @(negedge clk);
        if (rsp_valid) begin got = 1; rc = mcyc; end
      end
    end
    chk({nm, "_rsp_seen"}, {31'd0, got}, 32'd1);
    chk({nm, "_latency"}, 32'(rc - acc), 32'(exp_lat));
    chk({nm, "_result"}, rsp_result, exp_res);
    chk({nm, "_flag"}, {31'd0, rsp_flag}, {31'd0, exp_flag});
    chk({nm, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    if (hold > 0) force_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({nm, "_hold_result"}, rsp_result, exp_res);
      chk({nm, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({nm, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1; req_valid = 1'b0; force_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk({nm, "_ready_after_rsp"}, {31'd0, req_ready}, 32'd1);
    chk({nm, "_starts"}, 32'(starts), 32'(exp_starts));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin : main
    bit got;
    rst = 1'b0; req_valid = 1'b0; req_op = 5'd0; req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_opcode", {27'd0, alu_opcode}, 32'h1F);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    //   name          op        a             b           d  hold lat res           flg  err  starts
    run("add",        5'd0,  32'd5,        32'd5,        0, 0,  2,  32'd10,       1'b1, 1'b0, 0);
    run("mult",       5'd2,  32'd7,        32'd6,        5, 0,  7,  32'd42,       1'b0, 1'b0, 1);
    run("div_timeout",5'd3,  32'd100,      32'd7,        0, 0,  10, 32'd0,        1'b0, 1'b1, 1);
    run("illegal",    5'd21, 32'd1,        32'd2,        0, 0,  1,  32'd0,        1'b0, 1'b1, 0);
    run("sub_stall",  5'd1,  32'd20,       32'd3,        0, 4,  2,  32'd17,       1'b0, 1'b0, 0);
    run("div_lastcyc",5'd3,  32'd100,      32'd7,        8, 0,  10, 32'd14,       1'b0, 1'b0, 1);
    run("mult_late",  5'd2,  32'd3,        32'd3,        9, 0,  10, 32'd0,        1'b0, 1'b1, 1);
    run("mult_fast",  5'd2,  32'd3,        32'd3,        1, 2,  3,  32'd9,        1'b1, 1'b0, 1);
    run("op14",       5'd14, 32'd3,        32'd5,        0, 0,  2,  32'd6,        1'b0, 1'b0, 0);
    run("op15",       5'd15, 32'd3,        32'd5,        0, 0,  1,  32'd0,        1'b0, 1'b1, 0);

    // Spurious ALU done while idle must not produce anything.
    @(posedge clk); #1;
    force_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    force_valid = 1'b0;

    run("and",        5'd4,  32'h0000F0F0, 32'h0000FF00, 0, 0,  2,  32'h0000F000, 1'b0, 1'b0, 0);

    // Reset while waiting on a div that never completes.
    mc_delay = 0;
    starts = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 5'd3; req_a = 32'd9; req_b = 32'd2;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      if (!got) begin
        @(negedge clk);
        if (req_ready) got = 1;
      end
    end
    chk("midrst_accept", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_started", 32'(starts), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_opcode", {27'd0, alu_opcode}, 32'h1F);
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("midrst_alu_start", {31'd0, alu_start}, 32'd0);
    chk("midrst_in1", alu_in1, 32'd0);
    chk("midrst_err", {31'd0, rsp_err}, 32'd0);
`ifdef ALU_ISSUE_PERF_EN
    chk("midrst_perf_ops", perf_ops, 32'd0);
    chk("midrst_perf_busy", perf_busy, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;

    run("add_wrap",   5'd0,  32'hFFFFFFFF, 32'd1,        0, 0,  2,  32'd0,        1'b0, 1'b0, 0);
    run("mult_again", 5'd2,  32'd12,       32'd12,       3, 1,  5,  32'd144,      1'b1, 1'b0, 1);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
